// File: rtl/vpu_vreg_file.sv
// ---------------------------------------------------------------------------
// vpu_vreg_file
//
// Vector register file for the VPU datapath. It holds NUM_REGS registers.
// Each register is LANES lanes of LANE_W bits. Decode drives the two read
// ports and writeback drives the write port.
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   rst_n         asynchronous active-low reset; zeroes every register
//   rd_en_a/b     read request for port A/B
//   rd_addr_a/b   read address for port A/B
//   rd_data_a/b   registered read data; holds its value between reads
//   rd_valid_a/b  high for one cycle after an accepted read
//   wr_en         write request
//   wr_addr       write address
//   wr_data       write data; lane i is bits [i*LANE_W +: LANE_W]
//   wr_lane_mask  per-lane write enable; bit i gates lane i
//   clr_req       starts the clear-all sequence (pulse or level)
//   busy          high while the clear sequence is running
//
// Build option
//   VPU_VREG_BYPASS_EN  When defined, a read that hits the address being
//                       written in the same cycle returns the merged value.
//                       Lanes enabled in the mask come from wr_data. The
//                       other lanes come from the register. When undefined,
//                       that read returns the contents before the write.
// ---------------------------------------------------------------------------
module vpu_vreg_file #(
  parameter  int NUM_REGS = 8,
  parameter  int LANES    = 4,
  parameter  int LANE_W   = 16,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int VW       = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [VW-1:0]    rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [VW-1:0]    rd_data_b,
  output logic             rd_valid_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VW-1:0]    wr_data,
  input  logic [LANES-1:0] wr_lane_mask,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  // Every register needs an asynchronous reset to zero. This rules out a
  // RAM macro, so the storage is built from flops.
  logic [VW-1:0] mem_reg [NUM_REGS];

  logic [VW-1:0] rd_data_a_reg, rd_data_b_reg;
  logic          rd_valid_a_reg, rd_valid_b_reg;

  // Ports are only serviced while idle. During a clear, reads, writes and
  // new clear requests are all dropped.
  logic idle;
  logic wr_go, rd_go_a, rd_go_b;

  assign idle    = (state_reg == ST_IDLE);
  assign wr_go   = idle & wr_en;
  assign rd_go_a = idle & rd_en_a;
  assign rd_go_b = idle & rd_en_b;

  // Expand the lane mask to one enable bit per data bit. The write path and
  // the forwarding path can then merge with a plain AND/OR.
  logic [VW-1:0] wr_bits;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_bits
      assign wr_bits[gi*LANE_W +: LANE_W] = {LANE_W{wr_lane_mask[gi]}};
    end
  endgenerate

  logic [VW-1:0] wr_merged;
  assign wr_merged = (mem_reg[wr_addr] & ~wr_bits) | (wr_data & wr_bits);

  // Same-address forwarding. The forwarded word is the same merged value the
  // write stores, so it matches what a read on the next cycle would return.
  logic hit_a, hit_b;

`ifdef VPU_VREG_BYPASS_EN
  assign hit_a = wr_go && (wr_addr == rd_addr_a);
  assign hit_b = wr_go && (wr_addr == rd_addr_b);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  logic [VW-1:0] rd_word_a, rd_word_b;
  assign rd_word_a = hit_a ? wr_merged : mem_reg[rd_addr_a];
  assign rd_word_b = hit_b ? wr_merged : mem_reg[rd_addr_b];

  // ---------------------------------------------------------------------
  // Clear FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Clear FSM: next state
  // ---------------------------------------------------------------------
  // The sequence leaves CLEAR on the cycle that clears the last register.
  // At that point the counter has wrapped back to 0, because NUM_REGS is a
  // power of two.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == AW'(NUM_REGS - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Clear FSM: outputs
  // ---------------------------------------------------------------------
  // busy is decoded straight from the state flop. It therefore has no
  // combinational path from any input.
  always_comb begin
    busy = (state_reg == ST_CLEAR);
  end

  // ---------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------
  // A write and a clear request can arrive in the same idle cycle. The
  // write lands first, and the clear sequence then zeroes that register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_reg[r] <= '0;
      end
    end else if (state_reg == ST_CLEAR) begin
      mem_reg[cnt_reg] <= '0;
    end else if (wr_go) begin
      mem_reg[wr_addr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_reg  <= '0;
      rd_data_b_reg  <= '0;
      rd_valid_a_reg <= 1'b0;
      rd_valid_b_reg <= 1'b0;
    end else begin
      rd_valid_a_reg <= rd_go_a;
      rd_valid_b_reg <= rd_go_b;
      if (rd_go_a) begin
        rd_data_a_reg <= rd_word_a;
      end
      if (rd_go_b) begin
        rd_data_b_reg <= rd_word_b;
      end
    end
  end

  assign rd_data_a  = rd_data_a_reg;
  assign rd_data_b  = rd_data_b_reg;
  assign rd_valid_a = rd_valid_a_reg;
  assign rd_valid_b = rd_valid_b_reg;

endmodule

// File: tb/tb_vpu_vreg_file.sv
`timescale 1ns/1ps
// Testbench for vpu_vreg_file at the default sizes (8 x 4 x 16).
//
// Stimulus runs in the main initial block. Each read it issues pushes the
// expected data, and the cycle it should appear on, into a per-port queue.
// A separate monitor pops an entry whenever the DUT raises rd_valid.
module tb_vpu_vreg_file;

  localparam int NR = 8;
  localparam int LN = 4;
  localparam int LW = 16;
  localparam int AW = 3;
  localparam int VW = LN * LW;

`ifdef VPU_VREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
  logic [VW-1:0] wr_data = '0;
  logic [LN-1:0] wr_lane_mask = '0;
  logic [VW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy;

  typedef struct {
    logic [VW-1:0] data;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  vpu_vreg_file #(.NUM_REGS(NR), .LANES(LN), .LANE_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en_a      (rd_en_a),
    .rd_addr_a    (rd_addr_a),
    .rd_data_a    (rd_data_a),
    .rd_valid_a   (rd_valid_a),
    .rd_en_b      (rd_en_b),
    .rd_addr_b    (rd_addr_b),
    .rd_data_b    (rd_data_b),
    .rd_valid_b   (rd_valid_b),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_lane_mask (wr_lane_mask),
    .clr_req      (clr_req),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end else begin
      $display("chk  %s = %h", nm, got);
    end
  endtask

  task automatic judge(input string nm, input bit have, input exp_t e, input logic [VW-1:0] got);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s unexpected rd_valid at cyc %0d got=%h required=no read pending", nm, cyc, got);
    end else if (got !== e.data || cyc != e.due) begin
      n_bad++;
      $display("FAIL %s got=%h at cyc %0d required=%h at cyc %0d", nm, got, cyc, e.data, e.due);
    end else begin
      $display("read %s cyc %0d data=%h", nm, cyc, got);
    end
  endtask

  // Monitor: compare every read response against the scoreboard.
  always @(negedge clk) begin
    exp_t ea, eb;
    bit   ha, hb;
    ea = '{data: '0, due: 0};
    eb = '{data: '0, due: 0};
    if (rd_valid_a) begin
      ha = (qa.size() > 0);
      if (ha) ea = qa.pop_front();
      judge("rd_a", ha, ea, rd_data_a);
    end
    if (rd_valid_b) begin
      hb = (qb.size() > 0);
      if (hb) eb = qb.pop_front();
      judge("rd_b", hb, eb, rd_data_b);
    end
  end

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr_req = 1'b0;
    wr_lane_mask = '0;
  endtask

  // One idle-state cycle. Driven at a negedge and returns at the next one.
  task automatic op(input bit we, input logic [AW-1:0] wa, input logic [VW-1:0] wd,
                    input logic [LN-1:0] wm,
                    input bit ra_en, input logic [AW-1:0] ra, input logic [VW-1:0] ea,
                    input bit rb_en, input logic [AW-1:0] rb, input logic [VW-1:0] eb,
                    input bit clr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_lane_mask = wm;
    rd_en_a = ra_en; rd_addr_a = ra; rd_en_b = rb_en; rd_addr_b = rb;
    clr_req = clr;
    if (ra_en) qa.push_back('{data: ea, due: cyc + 1});
    if (rb_en) qb.push_back('{data: eb, due: cyc + 1});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [VW-1:0] d, input logic [LN-1:0] m);
    op(1'b1, a, d, m, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [VW-1:0] ea,
                    input logic [AW-1:0] b, input logic [VW-1:0] eb);
    op(1'b0, '0, '0, '0, 1'b1, a, ea, 1'b1, b, eb, 1'b0);
  endtask

  function automatic logic [VW-1:0] fillv(input int r);
    logic [LW-1:0] l;
    l = LW'(16'h1111 * (r + 1));
    return {LN{l}};
  endfunction

  task automatic fill();
    for (int r = 0; r < NR; r++) wr(AW'(r), fillv(r), 4'b1111);
  endtask

  task automatic read_all_zero();
    for (int r = 0; r < NR; r++) rd(AW'(r), '0, AW'(NR - 1 - r), '0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",       VW'(busy),       '0);
    chk("reset_rd_valid_a", VW'(rd_valid_a), '0);
    chk("reset_rd_valid_b", VW'(rd_valid_b), '0);
    chk("reset_rd_data_a",  rd_data_a,       '0);
    chk("reset_rd_data_b",  rd_data_b,       '0);
    rst_n = 1'b1;
    @(negedge clk);

    // All registers read back 0 after reset, on both ports.
    read_all_zero();

    // Lane masking: lanes 0 and 2 overwritten, lanes 1 and 3 kept.
    wr(3'd3, 64'h4444_3333_2222_1111, 4'b1111);
    wr(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
    rd(3'd3, 64'h4444_FFFF_2222_FFFF, 3'd3, 64'h4444_FFFF_2222_FFFF);
    // An empty mask with wr_en high changes nothing.
    wr(3'd3, 64'h0, 4'b0000);
    rd(3'd3, 64'h4444_FFFF_2222_FFFF, 3'd0, 64'h0);

    // Write and read of the same register in one cycle.
    op(1'b1, 3'd5, 64'hAAAA_BBBB_CCCC_DDDD, 4'b1111,
       1'b1, 3'd5, BYP ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h0,
       1'b0, 3'd0, 64'h0, 1'b0);
    rd(3'd5, 64'hAAAA_BBBB_CCCC_DDDD, 3'd5, 64'hAAAA_BBBB_CCCC_DDDD);
    // Partial-mask forwarding on port B: upper lanes come from the register (0).
    op(1'b1, 3'd6, 64'h1234_5678_9ABC_DEF0, 4'b0011,
       1'b0, 3'd0, 64'h0,
       1'b1, 3'd6, BYP ? 64'h0000_0000_9ABC_DEF0 : 64'h0, 1'b0);
    rd(3'd6, 64'h0000_0000_9ABC_DEF0, 3'd6, 64'h0000_0000_9ABC_DEF0);

    // Clear-all, issued together with a write to reg2 and a read of reg4.
    fill();
    op(1'b1, 3'd2, 64'hDEAD_BEEF_DEAD_BEEF, 4'b1111,
       1'b1, 3'd4, 64'h5555_5555_5555_5555,
       1'b0, 3'd0, 64'h0, 1'b1);
    n = 0;
    while (busy && n < 20) begin
      // Everything driven here must be ignored while busy.
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = '1; wr_lane_mask = '1;
      rd_en_a = 1'b1; rd_addr_a = 3'd1; rd_en_b = 1'b1; rd_addr_b = 3'd4;
      clr_req = 1'b1;
      if (n > 0) chk("busy_rd_valid_a", VW'(rd_valid_a), '0);
      chk("busy_rd_valid_b", VW'(rd_valid_b), '0);
      n++;
      @(negedge clk);
    end
    idle_inputs();
    chk("busy_cycles", VW'(n), VW'(NR));
    // A read is accepted on the first cycle busy is low.
    read_all_zero();

    // Reset asserted mid-clear, when the counter is at 4.
    fill();
    op(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_before_abort", VW'(busy), VW'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", VW'(busy), '0);
    chk("abort_rd_data_a", rd_data_a, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_busy", VW'(busy), '0);
    read_all_zero();
    wr(3'd7, 64'h7777_6666_5555_4444, 4'b1111);
    rd(3'd7, 64'h7777_6666_5555_4444, 3'd7, 64'h7777_6666_5555_4444);

    repeat (3) @(negedge clk);
    chk("qa_drained", VW'(qa.size()), '0);
    chk("qb_drained", VW'(qb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vpu_vreg_file.md
# vpu_vreg_file

Parametrised vector register file for the VPU datapath, successor to the single-port VPU register. It holds NUM_REGS vector registers of LANES × LANE_W bits and provides:
- two registered read ports;
- one write port with per-lane write masking;
- a sequenced clear-all operation;
- optional same-cycle write-to-read forwarding.

It sits between VPU decode (read addresses) and VPU writeback (write port).

## Interface
Parameters:
- NUM_REGS, 8, number of vector registers (power of two, ≥2)
- LANES, 4, lanes per vector register
- LANE_W, 16, bits per lane
- AW (derived, $clog2(NUM_REGS)), register address width; VW (derived, LANES*LANE_W), vector width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  AW  read address, port A
- rd_data_a  out  VW  registered read data, port A
- rd_valid_a  out  1  rd_data_a updated this cycle
- rd_en_b / rd_addr_b / rd_data_b / rd_valid_b  identical, port B
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  VW  write data, lane i = bits [i*LANE_W +: LANE_W]
- wr_lane_mask  in  LANES  per-lane write enable, bit i gates lane i
- clr_req  in  1  start clear-all sequence (single-cycle pulse or level)
- busy  out  1  clear sequence in progress

## Operation
Reset (rst_n low, asynchronous) forces:
- all registers to 0;
- rd_data_a/b to 0 and rd_valid_a/b to 0;
- busy to 0, FSM to IDLE, clear counter to 0.

Write:
- When wr_en is high in IDLE, each lane i with wr_lane_mask[i]=1 of reg[wr_addr] takes wr_data lane i at the clock edge.
- Unmasked lanes keep their value.
- wr_lane_mask=0 with wr_en=1 changes nothing.

Read:
- When rd_en_x is high in IDLE, rd_data_x <= reg[rd_addr_x] and rd_valid_x <= 1 at the edge.
- Otherwise rd_valid_x <= 0 and rd_data_x holds its last value.
- Both ports may read the same address in the same cycle.

Clear FSM, states IDLE and CLEAR:
- IDLE→CLEAR on clr_req=1. The counter loads 0.
- In CLEAR, each cycle reg[cnt] <= 0 and cnt increments.
- CLEAR→IDLE on the cycle that clears reg[NUM_REGS-1]. The counter wraps to 0.
- busy = (state==CLEAR), registered.
- In CLEAR, wr_en, rd_en_a/b and clr_req are ignored; rd_valid_a/b stay 0.
- If wr_en and clr_req are both high in IDLE, the write is performed and CLEAR starts on the next cycle. Net effect: that register is zeroed.
- If rd_en and clr_req are both high in IDLE, the read completes with pre-clear data.
- Reset asserted mid-CLEAR aborts to IDLE with all registers at 0.

## Timing
- Read latency: 1 cycle, from address at edge N to data/valid after edge N.
- Write visible to a read issued the following cycle, or the same cycle when forwarding is enabled.
- Clear: busy is high for exactly NUM_REGS cycles, starting the cycle after clr_req is sampled. A new read or write is accepted on the first cycle busy is low.
- There are no combinational paths from inputs to outputs.

## Configuration
VPU_VREG_BYPASS_EN:
- Defined: when a read and a write in IDLE hit the same address in the same cycle, rd_data gets the merged value. Masked lanes come from wr_data; the other lanes come from the register.
- Undefined: that read returns the pre-write register contents.
- The write itself is identical in both builds.

## Test plan
Defaults NUM_REGS=8, LANES=4, LANE_W=16.
- Reset then read all regs on A and B → every rd_data = 0, rd_valid high one cycle after each rd_en.
- Write reg3 = 0x4444_3333_2222_1111 with mask 4'b1111. Then write 0xFFFF_FFFF_FFFF_FFFF with mask 4'b0101. Read reg3 → 0x4444_FFFF_2222_FFFF.
- Same-cycle write reg5 = 0xAAAA_BBBB_CCCC_DDDD (mask 4'b1111, reg5 previously 0) plus read reg5 on port A → 0xAAAA_BBBB_CCCC_DDDD with VPU_VREG_BYPASS_EN, 0 without. A read of reg5 the next cycle returns the new value in both builds.
- Fill all regs nonzero, pulse clr_req with wr_en to reg2 in the same cycle. Expect busy high for exactly 8 cycles, writes and reads during busy ignored (rd_valid 0), and all regs read 0 afterward.
- Assert rst_n low during CLEAR at cnt=4 → busy 0 immediately, all regs read 0 after release. A subsequent write/read of reg7 works with 1-cycle latency.
